irq_ctrl: RTL and testbench

//  Interrupt controller for the CPLD's per-block interrupt sources (GPIO banks, etc.).

---
 rtl/irq_ctrl_if.sv | 30 +++
 rtl/irq_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if
//   Shared 5-bit-address / 8-bit-data CSR bus used by the CPLD blocks.
//   Signals:
//     csr_a   5  CSR address (master -> slave)
//     csr_di  8  write data (master -> slave)
//     csr_we  1  write strobe, one cycle per write (master -> slave)
//     csr_do  8  read data, combinational from csr_a (slave -> master)
//   Modports: master (bus owner, e.g. SoC bridge), slave (register block).
// ---------------------------------------------------------------------------
interface irq_ctrl_if;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (
        output csr_a,
        output csr_di,
        output csr_we,
        input  csr_do
    );

    modport slave (
        input  csr_a,
        input  csr_di,
        input  csr_we,
        output csr_do
    );
endinterface

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//   Interrupt controller for the CPLD's per-block interrupt sources.
//   Single-cycle source pulses latch into pending bits (IP), are masked per
//   source (IE), presented as a lowest-index-wins vector, and sequenced onto
//   one registered level interrupt with end-of-interrupt and a prescaled
//   hold-off period.
//
//   Ports:
//     clk     in   1        system clock
//     rst_n   in   1        asynchronous active-low reset
//     csr     slave         CSR bus (csr_a, csr_di, csr_we, csr_do)
//     irq_in  in   NUM_SRC  source pulses, active-high, synchronous to clk
//     irq     out  1        interrupt to SoC, active-high level, registered
//
//   Register map (offsets from BASE_ADDR, bits above NUM_SRC read 0):
//     +0 IE       rw     per-source enable
//     +1 IP       r/w1c  pending
//     +2 VECTOR   ro     {valid, 4'b0, lowest pending&enabled index}
//     +3 HOLDOFF  rw     hold-off length in ticks of 2**PRESCALE_W clocks
//     +4 CTRL     bit0 gen (rw), bit1 EOI (write-1 strobe, reads 0)
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter logic [4:0] BASE_ADDR   = 5'h00,
    parameter int         NUM_SRC     = 8,
    parameter int         PRESCALE_W  = 4,
    parameter logic [7:0] DFL_HOLDOFF = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    irq_ctrl_if.slave          csr,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    // Bits of the 8-bit registers that correspond to real sources.
    localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);
    localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1'b1);

    localparam logic [2:0] OFF_IE   = 3'd0;
    localparam logic [2:0] OFF_IP   = 3'd1;
    localparam logic [2:0] OFF_VEC  = 3'd2;
    localparam logic [2:0] OFF_HOLD = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Registers
    logic [7:0]            ie_r;
    logic [7:0]            ip_r;
    logic [7:0]            holdoff_r;
    logic                  gen_r;
    state_t                state_r;
    logic [7:0]            cnt_r;
    logic [PRESCALE_W-1:0] pre_r;
    logic                  irq_r;

    // Decode and next-value signals
    logic [5:0] off_s;
    logic       hit_s;
    logic [2:0] sel_s;
    logic       wr_ie_s;
    logic       wr_ip_s;
    logic       wr_hold_s;
    logic       wr_ctrl_s;
    logic [7:0] irq_in_s;
    logic [7:0] w1c_s;
    logic [7:0] ie_nxt_s;
    logic [7:0] ip_nxt_s;
    logic       gen_nxt_s;
    logic       eoi_s;
    logic       gen_clr_s;
    logic       act_s;
    logic       act_nxt_s;
    logic [7:0] pend_s;
    logic [7:0] vec_s;
    logic [7:0] do_s;

    // Address decode: a 6-bit difference keeps addresses below BASE_ADDR out of range.
    always_comb begin
        off_s = {1'b0, csr.csr_a} - {1'b0, BASE_ADDR};
        hit_s = ~off_s[5] & (off_s[4:0] <= 5'd4);
        sel_s = off_s[2:0];
    end

    // Write strobes, next register values and activity terms.
    always_comb begin
        wr_ie_s   = csr.csr_we & hit_s & (sel_s == OFF_IE);
        wr_ip_s   = csr.csr_we & hit_s & (sel_s == OFF_IP);
        wr_hold_s = csr.csr_we & hit_s & (sel_s == OFF_HOLD);
        wr_ctrl_s = csr.csr_we & hit_s & (sel_s == OFF_CTRL);

        irq_in_s  = 8'(irq_in) & SRC_MASK;
        if (wr_ip_s) begin
            w1c_s = csr.csr_di;
        end else begin
            w1c_s = 8'h00;
        end

        if (wr_ie_s) begin
            ie_nxt_s = csr.csr_di & SRC_MASK;
        end else begin
            ie_nxt_s = ie_r;
        end

        // A pulse arriving in the same cycle as its clear must not be lost,
        // so the new pulse is OR-ed in after the clear is applied.
        ip_nxt_s = ((ip_r & ~w1c_s) | irq_in_s) & SRC_MASK;

        if (wr_ctrl_s) begin
            gen_nxt_s = csr.csr_di[0];
        end else begin
            gen_nxt_s = gen_r;
        end
        eoi_s     = wr_ctrl_s & csr.csr_di[1];
        gen_clr_s = wr_ctrl_s & ~csr.csr_di[0];

        // act_s (registered view) starts an assertion, giving the two-cycle
        // pulse-to-irq latency. act_nxt_s looks at the values being written
        // this cycle so that masking or clearing drops irq on the very next
        // cycle, the same timing as an EOI.
        act_s     = gen_r & |(ip_r & ie_r);
        act_nxt_s = gen_nxt_s & |(ip_nxt_s & ie_nxt_s);

        pend_s    = ip_r & ie_r;
        if (|pend_s) begin
            vec_s = {1'b1, 4'b0000, lowest_idx(pend_s)};
        end else begin
            vec_s = 8'h00;
        end
    end

    // CSR read mux, combinational from the address.
    always_comb begin
        do_s = 8'h00;
        if (hit_s) begin
            case (sel_s)
                OFF_IE:   do_s = ie_r;
                OFF_IP:   do_s = ip_r;
                OFF_VEC:  do_s = vec_s;
                OFF_HOLD: do_s = holdoff_r;
                OFF_CTRL: do_s = {7'b0000000, gen_r};
                default:  do_s = 8'h00;
            endcase
        end else begin
            do_s = 8'h00;
        end
    end

    assign csr.csr_do = do_s;

    // Programmable registers: enables, pending bits, hold-off length, global enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_r      <= 8'h00;
            ip_r      <= 8'h00;
            holdoff_r <= DFL_HOLDOFF;
            gen_r     <= 1'b0;
        end else begin
            ie_r  <= ie_nxt_s;
            ip_r  <= ip_nxt_s;
            gen_r <= gen_nxt_s;
            if (wr_hold_s) begin
                holdoff_r <= csr.csr_di;
            end else begin
                holdoff_r <= holdoff_r;
            end
        end
    end

    // Sequencer: IDLE -> ASSERT on activity, EOI -> HOLD (or IDLE), HOLD
    // counts holdoff ticks of 2**PRESCALE_W clocks; irq is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'h00;
            pre_r   <= PRE_ZERO;
            irq_r   <= 1'b0;
        end else if (gen_clr_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'h00;
            pre_r   <= PRE_ZERO;
            irq_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (act_s) begin
                        state_r <= ST_ASSERT;
                        irq_r   <= 1'b1;
                    end else begin
                        irq_r   <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (eoi_s) begin
                        cnt_r <= holdoff_r;
                        pre_r <= PRE_ZERO;
                        irq_r <= 1'b0;
                        if (holdoff_r != 8'h00) begin
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (!act_nxt_s) begin
                        state_r <= ST_IDLE;
                        irq_r   <= 1'b0;
                    end else begin
                        irq_r   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    irq_r <= 1'b0;
                    pre_r <= pre_r + PRE_ONE;
                    if (&pre_r) begin
                        if (cnt_r == 8'h01) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 8'h00;
                        end else begin
                            cnt_r   <= cnt_r - 8'h01;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'h00;
                    pre_r   <= PRE_ZERO;
                    irq_r   <= 1'b0;
                end
            endcase
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl
//   Self-checking bench for irq_ctrl: a directed vector table covering
//   latency, priority/masking, collisions and cancel; hand-written sequences
//   for hold-off timing and asynchronous reset; then randomized CSR/pulse
//   traffic compared against a cycle-count reference model.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam logic [4:0] BASE = 5'h08;
    localparam logic [7:0] DFL  = 8'h02;
    localparam int         TICK = 16;

    localparam logic [4:0] A_IE   = BASE + 5'd0;
    localparam logic [4:0] A_IP   = BASE + 5'd1;
    localparam logic [4:0] A_VEC  = BASE + 5'd2;
    localparam logic [4:0] A_HOLD = BASE + 5'd3;
    localparam logic [4:0] A_CTRL = BASE + 5'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic       irq;

    int checks = 0;
    int failures = 0;

    irq_ctrl_if bus();

    irq_ctrl #(
        .BASE_ADDR  (BASE),
        .NUM_SRC    (8),
        .PRESCALE_W (4),
        .DFL_HOLDOFF(DFL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .csr   (bus.slave),
        .irq_in(irq_in),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [2:0] off;
        logic [7:0] di;
        logic [7:0] src;
        logic [2:0] rd_off;
        logic [7:0] exp_do;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[21];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
        bus.csr_a = a;
        #1;
        check8(name, bus.csr_do, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.csr_a  = a;
        bus.csr_di = d;
        bus.csr_we = 1'b1;
        tick();
        bus.csr_we = 1'b0;
    endtask

    function automatic logic [7:0] model_vec(input logic [7:0] pend);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (pend[i] && v == 8'h00) begin
                v = 8'h80 | 8'(i);
            end
        end
        return v;
    endfunction

    initial begin
        // Reference-model state for the random phase.
        logic [7:0] m_ie, m_ip, m_hold, n_ie, n_ip, n_hold;
        logic       m_gen, m_irq, n_gen, n_irq;
        int         m_left, n_left, hi_cnt;
        logic       we;
        logic [4:0] a, off;
        logic [7:0] di, src;
        logic       w_ie, w_ip, w_hold, w_ctrl, act_now, act_next;

        bus.csr_a  = 5'h00;
        bus.csr_di = 8'h00;
        bus.csr_we = 1'b0;

        //                we    off   di     src    rd    exp    irq
        tbl[0]  = '{1'b1, 3'd4, 8'h01, 8'h00, 3'd4, 8'h01, 1'b0};
        tbl[1]  = '{1'b1, 3'd0, 8'h04, 8'h00, 3'd0, 8'h04, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 8'h00, 8'h04, 3'd1, 8'h04, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 8'h82, 1'b1};
        tbl[4]  = '{1'b1, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 3'd0, 8'h04, 8'h00, 3'd0, 8'h04, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 8'h82, 1'b1};
        tbl[7]  = '{1'b1, 3'd1, 8'hFF, 8'h00, 3'd1, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 3'd0, 8'h0A, 8'h00, 3'd0, 8'h0A, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 8'h00, 8'h2A, 3'd1, 8'h2A, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 8'h81, 1'b1};
        tbl[11] = '{1'b1, 3'd1, 8'h02, 8'h00, 3'd2, 8'h83, 1'b1};
        tbl[12] = '{1'b1, 3'd1, 8'h08, 8'h00, 3'd2, 8'h00, 1'b0};
        tbl[13] = '{1'b1, 3'd1, 8'h01, 8'h01, 3'd1, 8'h21, 1'b0};
        tbl[14] = '{1'b1, 3'd0, 8'h01, 8'h00, 3'd0, 8'h01, 1'b0};
        tbl[15] = '{1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 8'h80, 1'b1};
        tbl[16] = '{1'b1, 3'd3, 8'h05, 8'h00, 3'd3, 8'h05, 1'b1};
        tbl[17] = '{1'b1, 3'd4, 8'h02, 8'h00, 3'd4, 8'h00, 1'b0};
        tbl[18] = '{1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 8'h80, 1'b0};
        tbl[19] = '{1'b1, 3'd4, 8'h01, 8'h00, 3'd4, 8'h01, 1'b0};
        tbl[20] = '{1'b0, 3'd0, 8'h00, 8'h00, 3'd2, 8'h80, 1'b1};

        // Reset state.
        #22;
        check8("rst_irq", {7'b0, irq}, 8'h00);
        rd_check("rst_ie", A_IE, 8'h00);
        rd_check("rst_ip", A_IP, 8'h00);
        rd_check("rst_vec", A_VEC, 8'h00);
        rd_check("rst_hold", A_HOLD, DFL);
        rd_check("rst_ctrl", A_CTRL, 8'h00);
        rst_n = 1'b1;
        tick();

        // Directed vector table.
        for (int i = 0; i < 21; i++) begin
            bus.csr_we = tbl[i].we;
            bus.csr_a  = BASE + {2'b00, tbl[i].off};
            bus.csr_di = tbl[i].di;
            irq_in     = tbl[i].src;
            tick();
            bus.csr_we = 1'b0;
            irq_in     = 8'h00;
            check8($sformatf("tbl%0d_irq", i), {7'b0, irq}, {7'b0, tbl[i].exp_irq});
            rd_check($sformatf("tbl%0d_do", i), BASE + {2'b00, tbl[i].rd_off}, tbl[i].exp_do);
        end

        // Hold-off: HOLDOFF=3 -> 48-cycle hold; a HOLDOFF write during HOLD
        // must not shorten it.
        wr(A_HOLD, 8'h03);
        check8("ho_pre_irq", {7'b0, irq}, 8'h01);
        wr(A_CTRL, 8'h03);                              // EOI at M
        check8("ho_eoi_low", {7'b0, irq}, 8'h00);       // M+1
        hi_cnt = 0;
        for (int c = 2; c <= 49; c++) begin
            if (c == 10) begin
                wr(A_HOLD, 8'h00);
            end else begin
                tick();
            end
            if (irq) hi_cnt++;
        end
        check8("ho_hold_low", 8'(hi_cnt), 8'h00);
        tick();                                         // M+50
        check8("ho_reassert", {7'b0, irq}, 8'h01);
        rd_check("ho_hold_rd", A_HOLD, 8'h00);
        wr(A_CTRL, 8'h03);                              // EOI with HOLDOFF=0
        check8("ho0_low", {7'b0, irq}, 8'h00);
        tick();
        check8("ho0_back", {7'b0, irq}, 8'h01);

        // Asynchronous reset mid-ASSERT.
        rst_n = 1'b0;
        #1;
        check8("arst_irq", {7'b0, irq}, 8'h00);
        rd_check("arst_ie", A_IE, 8'h00);
        rd_check("arst_ip", A_IP, 8'h00);
        rd_check("arst_vec", A_VEC, 8'h00);
        rd_check("arst_hold", A_HOLD, DFL);
        rd_check("arst_ctrl", A_CTRL, 8'h00);
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the reference model.
        m_ie = 8'h00; m_ip = 8'h00; m_hold = DFL; m_gen = 1'b0; m_irq = 1'b0; m_left = 0;
        for (int it = 0; it < 3000; it++) begin
            we = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 7) == 0) begin
                a = 5'(BASE + 5'd5 + 5'($urandom_range(0, 26)));
            end else begin
                a = 5'(BASE + 5'($urandom_range(0, 4)));
            end
            off = a - BASE;
            di = 8'($urandom);
            if (off == 5'd3) begin
                di = 8'($urandom_range(0, 3));
            end
            if (off == 5'd4) begin
                di[0] = ($urandom_range(0, 9) != 0);
            end
            src = ($urandom_range(0, 4) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;

            w_ie   = we && off == 5'd0;
            w_ip   = we && off == 5'd1;
            w_hold = we && off == 5'd3;
            w_ctrl = we && off == 5'd4;

            n_ie   = w_ie ? di : m_ie;
            n_ip   = (m_ip & ~(w_ip ? di : 8'h00)) | src;
            n_hold = w_hold ? di : m_hold;
            n_gen  = w_ctrl ? di[0] : m_gen;
            act_now  = m_gen && ((m_ip & m_ie) != 8'h00);
            act_next = n_gen && ((n_ip & n_ie) != 8'h00);
            n_left = 0;
            if (w_ctrl && !di[0]) begin
                n_irq = 1'b0;
            end else if (m_irq) begin
                if (w_ctrl && di[1]) begin
                    n_irq  = 1'b0;
                    n_left = int'(m_hold) * TICK;
                end else begin
                    n_irq = act_next;
                end
            end else if (m_left > 0) begin
                n_irq  = 1'b0;
                n_left = m_left - 1;
            end else begin
                n_irq = act_now;
            end

            bus.csr_we = we;
            bus.csr_a  = a;
            bus.csr_di = di;
            irq_in     = src;
            tick();
            bus.csr_we = 1'b0;
            irq_in     = 8'h00;

            m_ie = n_ie; m_ip = n_ip; m_hold = n_hold; m_gen = n_gen;
            m_irq = n_irq; m_left = n_left;

            check8("rnd_irq", {7'b0, irq}, {7'b0, m_irq});
            rd_check("rnd_ie", A_IE, m_ie);
            rd_check("rnd_ip", A_IP, m_ip);
            rd_check("rnd_vec", A_VEC, model_vec(m_ip & m_ie));
            rd_check("rnd_hold", A_HOLD, m_hold);
            rd_check("rnd_ctrl", A_CTRL, {7'b0, m_gen});
            rd_check("rnd_oor", 5'(BASE + 5'd5 + 5'($urandom_range(0, 26))), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
